// File: rtl/example_rs.sv
// Reservation-station scheduling core for one functional unit: tracks per-slot
// pending dependencies, clears them on wakeup, and requests issue when ready.
module example_rs #(
  parameter int unsigned RS_ENTRIES = 4,
  parameter int unsigned NUM_FUS    = 2,
  parameter int unsigned DW         = RS_ENTRIES * NUM_FUS,
  parameter int unsigned IW         = $clog2(RS_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  disp_valid,
  input  logic [DW-1:0]         dependency_mask,
  input  logic                  wake_valid,
  input  logic [DW-1:0]         wake_mask,
  input  logic [RS_ENTRIES-1:0] grant,
  output logic [IW-1:0]         free_entry_out,
  output logic                  full_out,
  output logic [RS_ENTRIES-1:0] reqs
);

  logic [RS_ENTRIES-1:0] entry_valid_q, entry_valid_d;
  logic [DW-1:0]         entry_deps_q [RS_ENTRIES];
  logic [DW-1:0]         entry_deps_d [RS_ENTRIES];

  // Hierarchically visible state aliases.
  logic [RS_ENTRIES-1:0] entry_valid;
  logic [DW-1:0]         entry_deps [RS_ENTRIES];

  logic [DW-1:0] wake_eff;
  logic          disp_fire;

  assign entry_valid = entry_valid_q;
  assign entry_deps  = entry_deps_q;

  assign wake_eff  = wake_valid ? wake_mask : '0;
  assign full_out  = &entry_valid_q;
  assign disp_fire = disp_valid & ~full_out;

  always_comb begin
    for (int i = 0; i < RS_ENTRIES; i++) begin
      reqs[i] = entry_valid_q[i] & ~(|entry_deps_q[i]);
    end
  end

  // Lowest-index free slot; scanning downwards lets the lowest index win.
  always_comb begin
    free_entry_out = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (!entry_valid_q[i]) begin
        free_entry_out = IW'(i);
      end
    end
  end

  always_comb begin
    entry_valid_d = entry_valid_q;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      entry_deps_d[i] = entry_deps_q[i];
      if (entry_valid_q[i]) begin
        entry_deps_d[i] = entry_deps_q[i] & ~wake_eff;
      end
      if (grant[i] && reqs[i]) begin
        entry_valid_d[i] = 1'b0;
        entry_deps_d[i]  = '0;
      end
      // Target is always an invalid slot, so it never collides with a grant.
      if (disp_fire && (free_entry_out == IW'(i))) begin
        entry_valid_d[i] = 1'b1;
        entry_deps_d[i]  = dependency_mask & ~wake_eff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_valid_q <= '0;
      for (int i = 0; i < RS_ENTRIES; i++) begin
        entry_deps_q[i] <= '0;
      end
    end else begin
      entry_valid_q <= entry_valid_d;
      for (int i = 0; i < RS_ENTRIES; i++) begin
        entry_deps_q[i] <= entry_deps_d[i];
      end
    end
  end

endmodule

// File: tb/tb_example_rs.sv
// Directed bench for example_rs with default parameters (4 slots, 8-bit masks).
module tb_example_rs;

  localparam int unsigned RsEntries = 4;
  localparam int unsigned Dw        = 8;
  localparam int unsigned Iw        = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 disp_valid;
  logic [Dw-1:0]        dependency_mask;
  logic                 wake_valid;
  logic [Dw-1:0]        wake_mask;
  logic [RsEntries-1:0] grant;
  logic [Iw-1:0]        free_entry_out;
  logic                 full_out;
  logic [RsEntries-1:0] reqs;

  int checks = 0;
  int errors = 0;

  example_rs dut (
    .clk             (clk),
    .rst             (rst),
    .disp_valid      (disp_valid),
    .dependency_mask (dependency_mask),
    .wake_valid      (wake_valid),
    .wake_mask       (wake_mask),
    .grant           (grant),
    .free_entry_out  (free_entry_out),
    .full_out        (full_out),
    .reqs            (reqs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic dv, input logic [Dw-1:0] dm,
                      input logic wv, input logic [Dw-1:0] wm, input logic [RsEntries-1:0] gr);
    @(negedge clk);
    rst             = r;
    disp_valid      = dv;
    dependency_mask = dm;
    wake_valid      = wv;
    wake_mask       = wm;
    grant           = gr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] v, input logic [3:0] rq,
                           input logic [1:0] fr, input logic fu);
    chk({tag, ".valid"}, 32'(dut.entry_valid), 32'(v));
    chk({tag, ".reqs"},  32'(reqs),            32'(rq));
    chk({tag, ".free"},  32'(free_entry_out),  32'(fr));
    chk({tag, ".full"},  32'(full_out),        32'(fu));
  endtask

  initial begin
    rst = 1'b1; disp_valid = 1'b0; dependency_mask = '0;
    wake_valid = 1'b0; wake_mask = '0; grant = '0;

    // Reset
    step(1, 0, 8'h00, 0, 8'h00, 4'b0000);
    step(1, 0, 8'h00, 0, 8'h00, 4'b0000);
    chk_state("reset", 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Zero-mask dispatch requests immediately
    step(0, 1, 8'h00, 0, 8'h00, 4'b0000);
    chk_state("disp0", 4'b0001, 4'b0001, 2'd1, 1'b0);
    step(0, 0, 8'h00, 0, 8'h00, 4'b0001);
    chk_state("grant0", 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Wakeup on a non-matching then matching bit
    step(0, 1, 8'h02, 0, 8'h00, 4'b0000);
    chk_state("dispdep", 4'b0001, 4'b0000, 2'd1, 1'b0);
    chk("dispdep.deps0", 32'(dut.entry_deps[0]), 32'h02);
    step(0, 0, 8'h00, 1, 8'h04, 4'b0000);
    chk("wake_miss.reqs", 32'(reqs), 32'h0);
    chk("wake_miss.deps0", 32'(dut.entry_deps[0]), 32'h02);
    step(0, 0, 8'h00, 1, 8'h02, 4'b0000);
    chk("wake_hit.reqs", 32'(reqs), 32'h1);
    chk("wake_hit.deps0", 32'(dut.entry_deps[0]), 32'h00);

    // Fill remaining slots
    step(0, 1, 8'h00, 0, 8'h00, 4'b0000);
    step(0, 1, 8'h10, 0, 8'h00, 4'b0000);
    step(0, 1, 8'h20, 0, 8'h00, 4'b0000);
    chk_state("full", 4'b1111, 4'b0011, 2'd0, 1'b1);

    // Dispatch while full is dropped
    step(0, 1, 8'h40, 0, 8'h00, 4'b0000);
    chk("drop.valid", 32'(dut.entry_valid), 32'hF);
    chk("drop.deps0", 32'(dut.entry_deps[0]), 32'h00);
    chk("drop.deps1", 32'(dut.entry_deps[1]), 32'h00);
    chk("drop.deps2", 32'(dut.entry_deps[2]), 32'h10);
    chk("drop.deps3", 32'(dut.entry_deps[3]), 32'h20);

    // Grant slot 1
    step(0, 0, 8'h00, 0, 8'h00, 4'b0010);
    chk_state("grant1", 4'b1101, 4'b0001, 2'd1, 1'b0);
    chk("grant1.deps1", 32'(dut.entry_deps[1]), 32'h00);

    // Same-cycle dispatch and wake resolve the dependency at entry
    step(0, 1, 8'h80, 1, 8'h80, 4'b0000);
    chk_state("dispwake", 4'b1111, 4'b0011, 2'd0, 1'b1);
    chk("dispwake.deps1", 32'(dut.entry_deps[1]), 32'h00);
    chk("dispwake.deps2", 32'(dut.entry_deps[2]), 32'h10);

    // Grant to a slot with pending deps is ignored
    step(0, 0, 8'h00, 0, 8'h00, 4'b0100);
    chk_state("grant_pend", 4'b1111, 4'b0011, 2'd0, 1'b1);

    // Full: grant frees slot 0 but the dispatch is still dropped
    step(0, 1, 8'h01, 0, 8'h00, 4'b0001);
    chk_state("full_gd", 4'b1110, 4'b0010, 2'd0, 1'b0);
    chk("full_gd.deps0", 32'(dut.entry_deps[0]), 32'h00);

    // Dispatch targets slot 0 (pre-edge free) while grant frees slot 1
    step(0, 1, 8'h04, 0, 8'h00, 4'b0010);
    chk_state("gd", 4'b1101, 4'b0000, 2'd1, 1'b0);
    chk("gd.deps0", 32'(dut.entry_deps[0]), 32'h04);

    // Multi-bit wake, then non-one-hot grant
    step(0, 0, 8'h00, 1, 8'h34, 4'b0000);
    chk_state("wake_multi", 4'b1101, 4'b1101, 2'd1, 1'b0);
    step(0, 0, 8'h00, 0, 8'h00, 4'b0111);
    chk_state("grant_multi", 4'b1000, 4'b1000, 2'd0, 1'b0);

    // Reset with three valid entries, competing with dispatch/wake/grant
    step(0, 1, 8'h01, 0, 8'h00, 4'b0000);
    step(0, 1, 8'h00, 0, 8'h00, 4'b0000);
    chk_state("pre_rst", 4'b1011, 4'b1010, 2'd2, 1'b0);
    step(1, 1, 8'h02, 1, 8'h01, 4'b1000);
    chk_state("mid_rst", 4'b0000, 4'b0000, 2'd0, 1'b0);
    chk("mid_rst.deps0", 32'(dut.entry_deps[0]), 32'h00);
    chk("mid_rst.deps2", 32'(dut.entry_deps[2]), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
